// File: rtl/rps4.sv
// 4-way rotating-priority arbiter: grant is combinational from req/en/count (zero latency).
// No backpressure; the rotation pointer advances every cycle regardless of en and req.
module rps4 (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       en,
  output logic [3:0] gnt,
  output logic [1:0] count
);

  logic [1:0] idx;
  logic       found;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= 2'd0;
    end else begin
      count <= count + 2'd1;
    end
  end

  // Walk downward from bit[count] with wrap-around; first requester wins.
  always_comb begin
    gnt   = 4'b0000;
    idx   = 2'd0;
    found = 1'b0;
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        idx = count - i[1:0];
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rps4.sv
// Directed bench for rps4: hand-computed grants per count, plus a per-cycle invariant monitor.
module tb_rps4;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic       en;
  logic [3:0] gnt;
  logic [1:0] count;

  int vectors;
  int miscompares;
  bit mon_on;

  rps4 dut (
    .clock(clock),
    .reset(reset),
    .req  (req),
    .en   (en),
    .gnt  (gnt),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_cnt);
    #1;
    vectors++;
    assert (gnt === exp_gnt) else begin
      miscompares++;
      $error("FAIL %s gnt=%b expected %b", tag, gnt, exp_gnt);
    end
    vectors++;
    assert (count === exp_cnt) else begin
      miscompares++;
      $error("FAIL %s count=%0d expected %0d", tag, count, exp_cnt);
    end
  endtask

  // Invariants: one-hot-or-zero and never granting a non-requester.
  always @(negedge clock) begin
    if (mon_on) begin
      vectors++;
      assert ($onehot0(gnt) === 1'b1) else begin
        miscompares++;
        $error("FAIL onehot gnt=%b expected one-hot or zero", gnt);
      end
      vectors++;
      assert ((gnt & ~req) === 4'b0000) else begin
        miscompares++;
        $error("FAIL subset gnt=%b req=%b expected gnt within req", gnt, req);
      end
    end
  end

  initial begin
    logic [1:0] c;
    vectors     = 0;
    miscompares = 0;
    mon_on      = 1'b0;
    reset       = 1'b0;
    en          = 1'b0;
    req         = 4'b0000;

    tick();
    mon_on = 1'b1;
    check("reset_idle", 4'b0000, 2'd0);
    en = 1'b1; req = 4'b0001;
    check("reset_comb_gnt", 4'b0001, 2'd0);
    tick();
    check("reset_hold", 4'b0001, 2'd0);

    reset = 1'b1;
    check("c0_req0001", 4'b0001, 2'd0);
    tick();
    req = 4'b0010;
    check("c1_req0010", 4'b0010, 2'd1);
    req = 4'b0101;
    check("c1_req0101", 4'b0001, 2'd1);
    tick();
    req = 4'b0101;
    check("c2_req0101", 4'b0100, 2'd2);
    req = 4'b1001;
    check("c2_req1001", 4'b0001, 2'd2);
    tick();
    req = 4'b0011;
    check("c3_req0011", 4'b0010, 2'd3);
    tick();
    req = 4'b1110;
    check("c0_req1110", 4'b1000, 2'd0);

    req = 4'b1111;
    check("full_c0", 4'b0001, 2'd0);
    tick();
    check("full_c1", 4'b0010, 2'd1);
    tick();
    check("full_c2", 4'b0100, 2'd2);
    tick();
    check("full_c3", 4'b1000, 2'd3);
    tick();
    check("full_wrap", 4'b0001, 2'd0);

    en = 1'b0;
    check("en0_c0", 4'b0000, 2'd0);
    tick();
    check("en0_c1", 4'b0000, 2'd1);

    tick();
    en = 1'b1; req = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      c = 2'd2 + k[1:0];
      check("noreq", 4'b0000, c);
      tick();
    end

    req = 4'b1111;
    check("pre_reset_c2", 4'b0100, 2'd2);
    reset = 1'b0;
    tick();
    check("midreset_c0", 4'b0001, 2'd0);
    reset = 1'b1;
    tick();
    check("post_reset_c1", 4'b0010, 2'd1);

    @(negedge clock);
    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
